com_tr_err_mon: RTL and testbench

Error-event monitor that sits on the receiving end of the `error_o` lines of up to `N_SRC` single-event-transient detectors (`com_tr` instances). It samples the detector error pulses, keeps saturating per-source and total event counters, and latches the first offending source. It raises a threshold alarm interrupt with an acknowledge handshake. Software or the safety unit reads the counters through a source-select port and clears them with a single-cycle command.

---
 rtl/com_tr_err_mon.sv | 204 ++++++++++++++++++++
 tb/tb_com_tr_err_mon.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/com_tr_err_mon.sv
// -----------------------------------------------------------------------------
// com_tr_err_mon
// Error-event monitor for the error_o lines of up to N_SRC transient detectors.
// It keeps a saturating counter per source and a saturating total. It latches
// the first source that produced an event and a sticky overflow flag. A
// threshold alarm on the total raises an interrupt, which is retired by an
// acknowledge.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   err_i          detector error lines, one per source
//   en_i           count enable (edge history is still tracked when low)
//   thr_i          alarm threshold on the total count, 0 disables the alarm
//   clr_i          one-cycle clear of counters, first capture, overflow, alarm
//   ack_i          alarm acknowledge
//   sel_i          source select for cnt_o
//   cnt_o          counter of source sel_i (0 when sel_i >= N_SRC)
//   total_o        total event counter
//   first_valid_o  a first event has been captured since the last clear/reset
//   first_src_o    lowest-index source of the first event cycle
//   irq_o          alarm interrupt
//   ovf_o          sticky: some counter saturated
// -----------------------------------------------------------------------------
module com_tr_err_mon #(
  parameter int N_SRC     = 4,
  parameter int CNT_WIDTH = 16,
  parameter int EDGE_MODE = 0,
  parameter int SEL_W     = $clog2(N_SRC)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SRC-1:0]     err_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] thr_i,
  input  logic                 clr_i,
  input  logic                 ack_i,
  input  logic [SEL_W-1:0]     sel_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] total_o,
  output logic                 first_valid_o,
  output logic [SEL_W-1:0]     first_src_o,
  output logic                 irq_o,
  output logic                 ovf_o
);

  // Total is summed wide enough that one cycle's popcount can never wrap it.
  localparam int SUM_W = CNT_WIDTH + SEL_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_ACKED = 2'd2
  } state_t;

  logic [N_SRC-1:0]     err_q;
  logic [N_SRC-1:0]     ev;
  logic [CNT_WIDTH-1:0] cnt_q [N_SRC];
  logic [CNT_WIDTH-1:0] cnt_d [N_SRC];
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [SUM_W-1:0]     tot_sum;
  logic                 first_valid_q, first_valid_d;
  logic [SEL_W-1:0]     first_src_q, first_src_d;
  logic                 ovf_q, ovf_d;
  state_t               state_q, state_d;

  function automatic logic [SUM_W-1:0] popcount(input logic [N_SRC-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SRC; i++) begin
      c = c + SUM_W'(v[i]);
    end
    return c;
  endfunction

  // Clamp a wide sum to the largest counter value.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [SUM_W-1:0] s);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return s[CNT_WIDTH-1:0];
  endfunction

  // Event vector: level or rising-edge qualified, gated by the enable.
  always_comb begin
    ev = '0;
    if (en_i) begin
      if (EDGE_MODE != 0) begin
        ev = err_i & ~err_q;
      end else begin
        ev = err_i;
      end
    end
  end

  // Counter, first-capture and overflow next state; clear overrides all.
  always_comb begin
    ovf_d         = ovf_q;
    first_valid_d = first_valid_q;
    first_src_d   = first_src_q;
    tot_sum       = SUM_W'(total_q) + popcount(ev);
    total_d       = sat_cnt(tot_sum);
    for (int k = 0; k < N_SRC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (ev[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
    if (tot_sum > SUM_W'(CNT_MAX)) begin
      ovf_d = 1'b1;
    end
    // Descending scan so the lowest active index is the one that sticks.
    if (!first_valid_q && (ev != '0)) begin
      first_valid_d = 1'b1;
      for (int k = N_SRC - 1; k >= 0; k--) begin
        if (ev[k]) begin
          first_src_d = SEL_W'(k);
        end
      end
    end
    if (clr_i) begin
      for (int k = 0; k < N_SRC; k++) begin
        cnt_d[k] = '0;
      end
      total_d       = '0;
      first_valid_d = 1'b0;
      first_src_d   = '0;
      ovf_d         = 1'b0;
    end
  end

  // Alarm FSM works on the registered total, giving one cycle of alarm latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((thr_i != '0) && (total_q >= thr_i)) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (ack_i) begin
          state_d = ST_ACKED;
        end
      end
      ST_ACKED: begin
        // Only a threshold raised above the count re-arms without a clear.
        if (thr_i > total_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q         <= '0;
      total_q       <= '0;
      first_valid_q <= 1'b0;
      first_src_q   <= '0;
      ovf_q         <= 1'b0;
      state_q       <= ST_IDLE;
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      err_q         <= err_i;
      total_q       <= total_d;
      first_valid_q <= first_valid_d;
      first_src_q   <= first_src_d;
      ovf_q         <= ovf_d;
      state_q       <= state_d;
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Read mux; selects beyond the last source read as zero.
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        cnt_o = cnt_q[k];
      end
    end
  end

  assign total_o       = total_q;
  assign first_valid_o = first_valid_q;
  assign first_src_o   = first_src_q;
  assign ovf_o         = ovf_q;
  assign irq_o         = (state_q == ST_ALARM);

endmodule

// File: tb/tb_com_tr_err_mon.sv
// -----------------------------------------------------------------------------
// tb_com_tr_err_mon
// Directed bench for com_tr_err_mon. Three instances share one stimulus:
//   u0 level mode, 16-bit counters
//   u1 edge mode,  16-bit counters
//   u2 level mode,  4-bit counters (saturation)
// -----------------------------------------------------------------------------
module tb_com_tr_err_mon;

  logic        clk;
  logic        rst;
  logic [3:0]  err;
  logic        en;
  logic [15:0] thr;
  logic        clr;
  logic        ack;
  logic [1:0]  sel;

  logic [15:0] cnt0, total0, cnt1, total1;
  logic [3:0]  cnt2, total2;
  logic        fv0, fv1, fv2;
  logic [1:0]  fs0, fs1, fs2;
  logic        irq0, irq1, irq2;
  logic        ovf0, ovf1, ovf2;

  int checks;
  int errors;

  com_tr_err_mon #(.N_SRC(4), .CNT_WIDTH(16), .EDGE_MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .err_i(err), .en_i(en), .thr_i(thr),
    .clr_i(clr), .ack_i(ack), .sel_i(sel), .cnt_o(cnt0), .total_o(total0),
    .first_valid_o(fv0), .first_src_o(fs0), .irq_o(irq0), .ovf_o(ovf0)
  );

  com_tr_err_mon #(.N_SRC(4), .CNT_WIDTH(16), .EDGE_MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .err_i(err), .en_i(en), .thr_i(thr),
    .clr_i(clr), .ack_i(ack), .sel_i(sel), .cnt_o(cnt1), .total_o(total1),
    .first_valid_o(fv1), .first_src_o(fs1), .irq_o(irq1), .ovf_o(ovf1)
  );

  com_tr_err_mon #(.N_SRC(4), .CNT_WIDTH(4), .EDGE_MODE(0)) u2 (
    .clk_i(clk), .rst_i(rst), .err_i(err), .en_i(en), .thr_i(thr[3:0]),
    .clr_i(clr), .ack_i(ack), .sel_i(sel), .cnt_o(cnt2), .total_o(total2),
    .first_valid_o(fv2), .first_src_o(fs2), .irq_o(irq2), .ovf_o(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    err = 4'h0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; err = 4'hF; en = 1'b1; thr = 16'd0;
    clr = 1'b0; ack = 1'b0; sel = 2'd0;

    // Reset held with all error lines active.
    step();
    step();
    chk("rst_total0", total0, 0);
    chk("rst_cnt0",   cnt0, 0);
    chk("rst_fv0",    fv0, 0);
    chk("rst_fs0",    fs0, 0);
    chk("rst_irq0",   irq0, 0);
    chk("rst_ovf0",   ovf0, 0);
    chk("rst_total1", total1, 0);
    rst = 1'b0;
    step();
    chk("post_rst_total0", total0, 4);
    chk("post_rst_fs0",    fs0, 0);
    chk("post_rst_fv0",    fv0, 1);
    chk("post_rst_total1", total1, 4);
    chk("post_rst_total2", total2, 4);

    // Clear together with events: events discarded.
    err = 4'hF;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ev_total0", total0, 0);
    chk("clr_ev_fv0",    fv0, 0);
    chk("clr_ev_total1", total1, 0);
    err = 4'h0;
    step();
    chk("clr_ev_after_total0", total0, 0);

    // Source 2 high for three cycles: level vs edge counting.
    sel = 2'd2;
    err = 4'b0100;
    step(); step(); step();
    err = 4'h0;
    step();
    chk("lvl_cnt0",   cnt0, 3);
    chk("lvl_total0", total0, 3);
    chk("lvl_fs0",    fs0, 2);
    chk("edge_cnt1",  cnt1, 1);
    chk("edge_total1", total1, 1);
    clear_all();

    // Threshold alarm at 5.
    thr = 16'd5;
    err = 4'b0001;
    step(); step(); step(); step();
    chk("alm_total4", total0, 4);
    chk("alm_irq_at4", irq0, 0);
    step();
    chk("alm_total5", total0, 5);
    chk("alm_irq_same_edge", irq0, 0);
    err = 4'h0;
    step();
    chk("alm_irq_fire", irq0, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("alm_irq_acked", irq0, 0);
    err = 4'b0001;
    step();
    err = 4'h0;
    step(); step();
    chk("alm_no_rearm_total", total0, 6);
    chk("alm_no_rearm_irq", irq0, 0);
    clear_all();
    chk("alm_clr_irq", irq0, 0);
    chk("alm_clr_total", total0, 0);
    err = 4'b0001;
    step(); step(); step(); step(); step();
    err = 4'h0;
    step();
    chk("alm_refire", irq0, 1);

    // Threshold lowered below the count while idle.
    thr = 16'd0;
    clear_all();
    err = 4'b0001;
    step(); step(); step();
    err = 4'h0;
    chk("thr_low_total", total0, 3);
    chk("thr_low_irq_before", irq0, 0);
    thr = 16'd2;
    step();
    chk("thr_low_irq", irq0, 1);
    thr = 16'd0;
    clear_all();

    // Saturation of the 4-bit instance.
    sel = 2'd1;
    err = 4'b0010;
    for (int i = 0; i < 15; i++) step();
    chk("sat15_cnt2",   cnt2, 15);
    chk("sat15_total2", total2, 15);
    chk("sat15_ovf2",   ovf2, 0);
    step();
    chk("sat16_cnt2", cnt2, 15);
    chk("sat16_ovf2", ovf2, 1);
    for (int i = 0; i < 4; i++) step();
    chk("sat20_cnt2",   cnt2, 15);
    chk("sat20_total2", total2, 15);
    chk("sat20_ovf2",   ovf2, 1);
    chk("sat20_cnt0",   cnt0, 20);
    chk("sat20_ovf0",   ovf0, 0);
    clear_all();
    chk("sat_clr_cnt2",   cnt2, 0);
    chk("sat_clr_total2", total2, 0);
    chk("sat_clr_ovf2",   ovf2, 0);

    // First-source capture.
    err = 4'b1010;
    step();
    chk("first_fs0", fs0, 1);
    chk("first_fv0", fv0, 1);
    chk("first_total0", total0, 2);
    err = 4'b0001;
    step();
    chk("first_keep_fs0", fs0, 1);
    clear_all();

    // Enable low: toggling lines are ignored.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err = (i % 2 == 0) ? 4'hF : 4'h0;
      step();
    end
    chk("en0_total0", total0, 0);
    chk("en0_total1", total1, 0);
    chk("en0_fv0",    fv0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
